// File: rtl/param_rom_stream_ctrl.sv
// Parameter ROM sequencer: sweeps all ROM words for a programmed number of
// passes and streams them out on valid/ready. Read requests are credited
// against a small output FIFO, so backpressure never drops or repeats a word.
module param_rom_stream_ctrl #(
  parameter int OUT_SIZE    = 32,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_DEPTH   = 8,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [15:0]                           passes,
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_WIDTH-1:0]                 rom_addr,
  output logic                                  rom_ce,
  input  logic [OUT_WIDTH*OUT_SIZE-1:0]         rom_q,
  output logic [OUT_SIZE-1:0][OUT_WIDTH-1:0]    data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready
);

  // One buffer slot per in-flight read plus one, so the issue path can keep
  // streaming at full rate while a word sits at the head.
  localparam int FIFO_DEPTH = ROM_LATENCY + 1;
  localparam int WORD_W     = OUT_WIDTH * OUT_SIZE;
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W      = $clog2(ROM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [15:0]             pass_left_q, pass_left_d;
  logic [ROM_LATENCY-1:0]  vld_q, vld_d;
  logic [WORD_W-1:0]       mem_q [FIFO_DEPTH];
  logic [WORD_W-1:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    busy_q, busy_d, done_q, done_d;

  logic                    push, pop, issue;
  logic [INF_W-1:0]        inflight;
  int                      occ;
  logic [WORD_W-1:0]       head;

  // ROM pipeline free-runs outside reset; address comes straight from the counter.
  assign rom_ce         = ~rst;
  assign rom_addr       = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign data_out_valid = (count_q != '0);

  // Unpack the FIFO head into output elements.
  always_comb begin
    head = mem_q[rd_ptr_q];
    for (int j = 0; j < OUT_SIZE; j++)
      data_out[j] = head[OUT_WIDTH*j +: OUT_WIDTH];
  end

  // Next-state: credit-based issue, read tracking, FIFO and sequencing FSM.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_left_d = pass_left_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    pop  = data_out_valid & data_out_ready;
    push = vld_q[ROM_LATENCY-1];

    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++)
      inflight = inflight + INF_W'(vld_q[i]);

    // Every outstanding read must have a slot waiting when it lands; a pop
    // this cycle frees one, so issue can resume on the same cycle.
    occ   = int'(count_q) + int'(inflight) - int'(pop);
    issue = (state_q == ISSUE) && (occ < FIFO_DEPTH);

    vld_d[0] = issue;
    for (int i = 1; i < ROM_LATENCY; i++)
      vld_d[i] = vld_q[i-1];

    if (push) begin
      mem_d[wr_ptr_q] = rom_q;
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    case (state_q)
      IDLE: begin
        if (start) begin
          pass_left_d = passes;
          addr_d      = '0;
          state_d     = (passes == 16'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          if (addr_q == ADDR_WIDTH'(OUT_DEPTH-1)) begin
            addr_d      = '0;
            pass_left_d = pass_left_q - 16'd1;
            if (pass_left_q == 16'd1) state_d = DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      // Finish as soon as the last word leaves, looking at post-edge occupancy
      // so done lands the cycle right after the final handshake.
      DRAIN: begin
        if ((count_d == '0) && (vld_d == '0)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // State registers; synchronous reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pass_left_q <= '0;
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_left_q <= pass_left_d;
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: doc/param_rom_stream_ctrl.md
# param_rom_stream_ctrl

Sequencing controller for a generated parameter ROM (weights or bias) with a fixed 2-cycle, `ce`-gated read pipeline. It replaces the always-valid, latency-unaware parameter source.

- On a `start` command, it streams all `OUT_DEPTH` ROM words in address order.
- It repeats the sweep a programmable number of passes.
- It presents each word as an `OUT_SIZE`-element vector on a valid/ready stream toward the compute blocks.
- It tracks in-flight reads and buffers them, so no word is dropped or duplicated under backpressure.

## Interface

Parameters:
- `OUT_SIZE`, 32: elements per ROM word.
- `OUT_WIDTH`, 16: bits per element.
- `OUT_DEPTH`, 8: ROM words per pass (≥1).
- `ROM_LATENCY`, 2: cycles from `rom_addr`/`rom_ce` to `rom_q`.
- `ADDR_WIDTH`, $clog2(OUT_DEPTH)+1: ROM address width.
- `FIFO_DEPTH`, ROM_LATENCY+1: output buffer entries (derived; not overridden).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle command pulse; ignored unless state is IDLE.
- `passes` in 16: number of full sweeps; sampled on accepted `start`.
- `busy` out 1: high in ISSUE or DRAIN.
- `done` out 1: one-cycle pulse after the final word is accepted.
- `rom_addr` out ADDR_WIDTH: ROM read address.
- `rom_ce` out 1: ROM clock enable.
- `rom_q` in OUT_WIDTH*OUT_SIZE: ROM read data.
- `data_out` out [OUT_WIDTH-1:0] x [OUT_SIZE-1:0]: element j = `rom_q` bits [OUT_WIDTH*j +: OUT_WIDTH].
- `data_out_valid` out 1: FIFO non-empty.
- `data_out_ready` in 1: consumer ready.

## Operation

- **FSM states:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - On `start`, latch `passes` into `pass_left` and clear `addr` to 0.
  - If `passes`==0, go directly to DONE (no ROM reads, no output). Otherwise go to ISSUE.
- **ISSUE:**
  - Issue a read when `fifo_count + inflight - pop < FIFO_DEPTH`, where `pop` = `data_out_valid & data_out_ready`.
  - An issue pushes a 1 into the `ROM_LATENCY`-deep valid shift register; a non-issue cycle pushes a 0.
  - `addr` increments on each issue and wraps to 0 after `OUT_DEPTH-1`.
  - A wrap decrements `pass_left`.
  - Issuing the last address while `pass_left`==1 transitions to DRAIN.
- **DRAIN:** no issues. Move to DONE when `inflight`==0 and the FIFO is empty.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **ROM interface:**
  - `rom_ce` is held at 1 whenever not in reset, so the ROM pipeline free-runs.
  - `rom_addr` = `addr`.
- **Capture:** when the valid shift register's tail bit is 1, `rom_q` is written into the FIFO that cycle.
- **FIFO:**
  - Circular, with registered storage and `count` in 0..FIFO_DEPTH.
  - Simultaneous push and pop leave `count` unchanged.
  - Overflow is impossible by the credit rule. The bench asserts `count` ≤ FIFO_DEPTH.
- **`inflight`:** number of 1s in the valid shift register (0..ROM_LATENCY).
- **`data_out`:** combinational unpack of the FIFO head; holds stable while valid and not ready.
- **Reset (including mid-operation):**
  - State returns to IDLE.
  - `busy`, `done`, `data_out_valid`, and `rom_addr` all go to 0.
  - FIFO and shift register are cleared; in-flight ROM data is discarded.
  - `rom_ce`=0 during reset.

## Timing

- `start` at cycle 0 → ISSUE and `busy`=1 in cycle 1. First `rom_addr`=0 is issued in cycle 1.
- Start-to-output latency:
  - `rom_q` is valid in cycle 1+ROM_LATENCY and captured at the end of that cycle.
  - `data_out_valid`=1 in cycle 2+ROM_LATENCY (cycle 4 at default).
- **Throughput:** with `data_out_ready` held at 1, one word per cycle, no bubbles, across pass boundaries.
- **Backpressure:**
  - With `data_out_ready`=0, issue stops once `fifo_count + inflight` reaches FIFO_DEPTH.
  - When ready returns, issue resumes in the same cycle as the first pop.
- **Completion:** `done` is asserted in the cycle after the final handshake and empty FIFO. `busy` falls in that same cycle.
- **`start` while busy:** ignored. `passes` changes while busy have no effect.

## Test plan

- **Single pass.** OUT_DEPTH=4, OUT_SIZE=2, OUT_WIDTH=8, ROM word k={8'(2k+1),8'(2k)}; `passes`=1; ready=1; `start` at cycle 0.
  - `data_out_valid` in cycles 4–7.
  - `data_out[0]` = 0, 2, 4, 6.
  - `done` in cycle 8; `busy` 1→0 in cycle 8.
- **Multi-pass wrap.** `passes`=3; ready=1.
  - 12 consecutive words with no bubble; addresses 0,1,2,3 repeated three times.
  - Exactly one `done` pulse.
- **Backpressure.** Same setup; ready=0 for cycles 3–12, then 1.
  - At most FIFO_DEPTH=3 words issued before the stall; `data_out` is stable while stalled.
  - All 4 words delivered in order; no duplicates.
- **Random ready.** 50% random `data_out_ready`, `passes`=5.
  - Scoreboard matches 20 words in order.
  - FIFO never exceeds 3 entries.
- **Zero passes and ignored start.**
  - `passes`=0: `done` in cycle 1, no valid output.
  - `start` pulsed while busy: no effect on word count.
- **Reset mid-stream.** Assert `rst` after the 2nd word.
  - All outputs return to 0 in the next cycle.
  - A following `start` streams from address 0 with no stale data.
